sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO, the next generation of the team's 16x16 Synchronous_FIFO. It adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It is used as the generic single-clock buffer between producer and consumer datapaths.

---
 rtl/sync_fifo_param.sv | 96 +++++++++
 tb/tb_sync_fifo_param.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, sticky
// overflow/underflow and a selectable first-word-fall-through read port.
module sync_fifo_param #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4,
  parameter bit FWFT      = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_en,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     r_en,
  output logic [DATA_W-1:0]        data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              afull_q, afull_d, aempty_q, aempty_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              rd_ok, wr_ok;

  always_comb begin
    rd_ok   = r_en & ~empty_q;
    // a full FIFO may still take a write when the same edge pops a word
    wr_ok   = w_en & (~full_q | rd_ok);
    w_ptr_d = wr_ok ? w_ptr_q + AW'(1) : w_ptr_q;
    r_ptr_d = rd_ok ? r_ptr_q + AW'(1) : r_ptr_q;
    count_d = count_q;
    if (wr_ok & ~rd_ok)      count_d = count_q + CW'(1);
    else if (rd_ok & ~wr_ok) count_d = count_q - CW'(1);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CW'(AFULL_TH));
    aempty_d = (count_d <= CW'(AEMPTY_TH));
    // a new error in the same cycle as clr_err wins
    ovf_d    = (ovf_q & ~clr_err) | (w_en & ~wr_ok);
    udf_d    = (udf_q & ~clr_err) | (r_en & ~rd_ok);
    dout_d   = rd_ok ? mem[r_ptr_q] : dout_q;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[w_ptr_q] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr_q  <= '0;
      r_ptr_q  <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      w_ptr_q  <= w_ptr_d;
      r_ptr_q  <= r_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      dout_q   <= dout_d;
    end
  end

  // FWFT shows the head word directly; zero while empty keeps it defined
  assign data_out     = FWFT ? (empty_q ? '0 : mem[r_ptr_q]) : dout_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: vector table, hand sequences and random traffic
// checked against a queue-based reference model; second instance in FWFT mode.
module tb_sync_fifo_param;
  localparam int DW = 16, DEPTH = 16, AF = 12, AE = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, w_en, r_en, clr_err;
  logic [DW-1:0] data_in, data_out;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0] count;

  logic          f_rst, f_w, f_r, f_clr;
  logic [DW-1:0] f_din, f_dout;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [CW-1:0] f_cnt;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1'b0)) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en), .data_out(data_out),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow), .clr_err(clr_err));

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1'b1)) dut_fwft (
    .clk(clk), .rst(f_rst), .w_en(f_w), .data_in(f_din), .r_en(f_r), .data_out(f_dout),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_cnt), .overflow(f_ovf), .underflow(f_udf), .clr_err(f_clr));

  int vectors = 0, miscompares = 0;

  // reference model: contents as a queue plus sticky flags and the read register
  logic [DW-1:0] mq[$];
  logic          m_ovf, m_udf;
  logic [DW-1:0] m_dout;

  typedef struct {
    bit          w, r, clr;
    logic [DW-1:0] din;
    int          cnt;
    logic [DW-1:0] dout;
    bit          ovf, udf;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic [DW-1:0] dout,
                           input bit ovf, input bit udf);
    chk({tag, ".count"}, 32'(count), cnt);
    chk({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
    chk({tag, ".full"}, 32'(full), 32'(cnt == DEPTH));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(cnt >= AF));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(cnt <= AE));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(udf));
    chk({tag, ".data_out"}, 32'(data_out), 32'(dout));
  endtask

  task automatic do_reset();
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_dout = '0;
  endtask

  // one clock of traffic; the model applies the acceptance rules to its pre-edge state
  task automatic step(input string tag, input bit w, input bit r, input bit c, input logic [DW-1:0] d);
    bit rd_ok, wr_ok;
    w_en = w; r_en = r; clr_err = c; data_in = d;
    rd_ok = r && (mq.size() != 0);
    wr_ok = w && (mq.size() != DEPTH || rd_ok);
    @(posedge clk);
    if (rd_ok) m_dout = mq.pop_front();
    if (wr_ok) mq.push_back(d);
    if (c) begin m_ovf = 1'b0; m_udf = 1'b0; end
    if (w && !wr_ok) m_ovf = 1'b1;
    if (r && !rd_ok) m_udf = 1'b1;
    #1;
    w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
    chk_state(tag, mq.size(), m_dout, m_ovf, m_udf);
  endtask

  initial begin
    f_rst = 1'b1; f_w = 1'b0; f_r = 1'b0; f_clr = 1'b0; f_din = '0;

    // reset state
    do_reset();
    chk_state("reset", 0, 16'h0000, 1'b0, 1'b0);

    // fill, overflow, drain, then error flag clearing
    for (int i = 0; i < DEPTH; i++)
      tbl.push_back('{w:1, r:0, clr:0, din:DW'(i + 1), cnt:i + 1, dout:16'h0000, ovf:0, udf:0});
    tbl.push_back('{w:1, r:0, clr:0, din:16'hDEAD, cnt:DEPTH, dout:16'h0000, ovf:1, udf:0});
    for (int i = 0; i < DEPTH; i++)
      tbl.push_back('{w:0, r:1, clr:0, din:16'h0, cnt:DEPTH - 1 - i, dout:DW'(i + 1), ovf:1, udf:0});
    tbl.push_back('{w:0, r:0, clr:1, din:16'h0, cnt:0, dout:16'h0010, ovf:0, udf:0});
    tbl.push_back('{w:0, r:1, clr:0, din:16'h0, cnt:0, dout:16'h0010, ovf:0, udf:1});
    tbl.push_back('{w:0, r:0, clr:1, din:16'h0, cnt:0, dout:16'h0010, ovf:0, udf:0});
    tbl.push_back('{w:0, r:1, clr:1, din:16'h0, cnt:0, dout:16'h0010, ovf:0, udf:1});
    foreach (tbl[i]) begin
      w_en = tbl[i].w; r_en = tbl[i].r; clr_err = tbl[i].clr; data_in = tbl[i].din;
      @(posedge clk); #1;
      chk_state($sformatf("tbl[%0d]", i), tbl[i].cnt, tbl[i].dout, tbl[i].ovf, tbl[i].udf);
    end

    // pointer wrap: three 10-deep bursts then a 16-word pattern
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) step("wrap.w", 1'b1, 1'b0, 1'b0, DW'($urandom));
      for (int i = 0; i < 10; i++) step("wrap.r", 1'b0, 1'b1, 1'b0, '0);
    end
    for (int i = 0; i < DEPTH; i++) step("wrapA5.w", 1'b1, 1'b0, 1'b0, 16'hA500 + DW'(i));
    for (int i = 0; i < DEPTH; i++) step("wrapA5.r", 1'b0, 1'b1, 1'b0, '0);

    // simultaneous read+write at full, then at empty
    for (int i = 0; i < DEPTH; i++) step("full.w", 1'b1, 1'b0, 1'b0, 16'h3000 + DW'(i));
    step("full.rw", 1'b1, 1'b1, 1'b0, 16'hBEEF);
    chk("full.rw.count16", 32'(count), 32'(DEPTH));
    chk("full.rw.dout", 32'(data_out), 32'h3000);
    chk("full.rw.no_ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < DEPTH; i++) step("full.drain", 1'b0, 1'b1, 1'b0, '0);
    chk("full.last_beef", 32'(data_out), 32'hBEEF);
    step("empty.rw", 1'b1, 1'b1, 1'b0, 16'h5555);
    chk("empty.rw.count1", 32'(count), 32'h1);
    chk("empty.rw.udf", 32'(underflow), 32'h1);
    chk("empty.rw.dout_held", 32'(data_out), 32'hBEEF);

    // random traffic with alternating fill/drain bias and one asynchronous reset
    for (int i = 0; i < 1600; i++) begin
      int wp;
      wp = ((i / 150) % 2 == 0) ? 75 : 25;
      if (i == 800) begin
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rand.async_rst.count", 32'(count), 32'h0);
        chk("rand.async_rst.empty", 32'(empty), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        mq.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_dout = '0;
      end
      step("rand", $urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
           $urandom_range(0, 31) == 0, DW'($urandom));
    end

    // FWFT instance: fall-through, pop to empty, reset mid-burst
    @(posedge clk); #1 f_rst = 1'b0;
    f_w = 1'b1; f_din = 16'h1234;
    @(posedge clk); #1 f_w = 1'b0;
    chk("fwft.show", 32'(f_dout), 32'h1234);
    chk("fwft.not_empty", 32'(f_empty), 32'h0);
    @(posedge clk); #1;
    chk("fwft.hold", 32'(f_dout), 32'h1234);
    f_r = 1'b1;
    @(posedge clk); #1 f_r = 1'b0;
    chk("fwft.pop_empty", 32'(f_empty), 32'h1);
    for (int i = 0; i < 7; i++) begin
      f_w = 1'b1; f_din = 16'h7000 + DW'(i);
      @(posedge clk); #1;
    end
    f_w = 1'b0;
    chk("fwft.count7", 32'(f_cnt), 32'h7);
    chk("fwft.head", 32'(f_dout), 32'h7000);
    f_r = 1'b1;
    @(posedge clk); #1 f_r = 1'b0;
    chk("fwft.next", 32'(f_dout), 32'h7001);
    f_w = 1'b1; f_din = 16'h7007;
    @(posedge clk); #1;
    chk("fwft.count7b", 32'(f_cnt), 32'h7);
    #2 f_rst = 1'b1;
    #1;
    chk("fwft.rst.count", 32'(f_cnt), 32'h0);
    chk("fwft.rst.empty", 32'(f_empty), 32'h1);
    f_w = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
